rx_sync_ctrl: RTL

Receive-side link synchronization controller for the 8b/10b RX channel. It watches the decoded byte stream for K28.5 commas and runs an acquire/hold/loss state machine. It gates the forwarded data so the downstream logic only sees bytes received while the link is in sync. It sits between the decoded RX byte path and the RX consumer, and it counts code errors and loss-of-sync events.

---
 rtl/rx_sync_if.sv | 32 +++
 rtl/rx_sync_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rx_sync_if.sv
// -----------------------------------------------------------------------------
// rx_sync_if
// Bundles the decoded RX symbol path into rx_sync_ctrl and the gated,
// registered symbol path plus status out of it.
//   rx_valid/rx_data/rx_control/rx_err : decoded symbol (producer -> ctrl)
//   rx_dataS/rx_ctrlS/rx_validS        : forwarded symbol (ctrl -> consumer)
//   sync_ok/comma_det/err_cnt/loss_cnt : link status
// master: symbol producer / status observer.  slave: rx_sync_ctrl.
// -----------------------------------------------------------------------------
interface rx_sync_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_control;
   logic       rx_err;
   logic [7:0] rx_dataS;
   logic       rx_ctrlS;
   logic       rx_validS;
   logic       sync_ok;
   logic       comma_det;
   logic [3:0] err_cnt;
   logic [7:0] loss_cnt;

   modport master (
      output rx_valid, rx_data, rx_control, rx_err,
      input  rx_dataS, rx_ctrlS, rx_validS, sync_ok, comma_det, err_cnt, loss_cnt
   );

   modport slave (
      input  rx_valid, rx_data, rx_control, rx_err,
      output rx_dataS, rx_ctrlS, rx_validS, sync_ok, comma_det, err_cnt, loss_cnt
   );
endinterface

// File: rtl/rx_sync_ctrl.sv
// -----------------------------------------------------------------------------
// rx_sync_ctrl
// 8b/10b RX link synchronisation controller. Hunts for K28.5 commas, runs a
// LOS -> ACQ -> SYNC state machine, and forwards decoded bytes downstream only
// while in SYNC. Tracks a leaky error counter and a saturating loss counter.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   enb  - clock enable; when low all state holds and rx_validS goes 0
//   bus  - rx_sync_if.slave: decoded symbol in, forwarded symbol + status out
//
// Optional build macro: RX_SYNC_COMMA_STRIP_EN
//   When defined, comma symbols received in SYNC are not forwarded.
// -----------------------------------------------------------------------------
module rx_sync_ctrl #(
   parameter logic [7:0] COMMA    = 8'hBC,
   parameter int         N_ACQ    = 3,
   parameter int         N_LOSS   = 4,
   parameter int         GOOD_RUN = 4
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     enb,
   rx_sync_if.slave bus
);

   typedef enum logic [1:0] {
      LOS  = 2'd0,
      ACQ  = 2'd1,
      SYNC = 2'd2
   } state_t;

   localparam logic [3:0] N_ACQ_W    = 4'(N_ACQ);
   localparam logic [3:0] N_LOSS_W   = 4'(N_LOSS);
   localparam logic [3:0] GOOD_RUN_W = 4'(GOOD_RUN);

   state_t     state, state_nxt;
   logic [3:0] comma_cnt, comma_cnt_nxt;
   logic [3:0] good_cnt, good_cnt_nxt;
   logic [3:0] err_cnt_q, err_cnt_nxt;
   logic [7:0] loss_q, loss_nxt;

   logic [7:0] data_q;
   logic       ctrl_q;
   logic       valid_q;
   logic       comma_det_q;

   logic       ev, comma, err, comma_sym, fwd;
   logic [3:0] comma_inc, good_inc, err_inc;

   assign ev        = enb & bus.rx_valid;
   assign comma_sym = bus.rx_control & (bus.rx_data == COMMA);
   // An errored comma is treated purely as an error.
   assign comma     = ev & comma_sym & ~bus.rx_err;
   assign err       = ev & bus.rx_err;

   assign comma_inc = comma_cnt + 4'd1;
   assign good_inc  = good_cnt + 4'd1;
   assign err_inc   = err_cnt_q + 4'd1;

   always_comb begin
      state_nxt     = state;
      comma_cnt_nxt = comma_cnt;
      good_cnt_nxt  = good_cnt;
      err_cnt_nxt   = err_cnt_q;
      loss_nxt      = loss_q;
      case (state)
         LOS: begin
            if (comma) begin
               if (N_ACQ_W == 4'd1) begin
                  state_nxt     = SYNC;
                  comma_cnt_nxt = 4'd0;
                  err_cnt_nxt   = 4'd0;
                  good_cnt_nxt  = 4'd0;
               end else begin
                  state_nxt     = ACQ;
                  comma_cnt_nxt = 4'd1;
               end
            end
         end
         ACQ: begin
            if (err) begin
               state_nxt     = LOS;
               comma_cnt_nxt = 4'd0;
            end else if (comma) begin
               if (comma_inc == N_ACQ_W) begin
                  state_nxt     = SYNC;
                  comma_cnt_nxt = 4'd0;
                  err_cnt_nxt   = 4'd0;
                  good_cnt_nxt  = 4'd0;
               end else begin
                  comma_cnt_nxt = comma_inc;
               end
            end
         end
         SYNC: begin
            if (err) begin
               good_cnt_nxt = 4'd0;
               if (err_inc == N_LOSS_W) begin
                  state_nxt   = LOS;
                  err_cnt_nxt = 4'd0;
                  if (loss_q != 8'hFF) loss_nxt = loss_q + 8'd1;
               end else begin
                  err_cnt_nxt = err_inc;
               end
            end else if (ev) begin
               // Leaky bucket: every GOOD_RUN clean symbols forgive one error.
               if (good_inc == GOOD_RUN_W) begin
                  good_cnt_nxt = 4'd0;
                  if (err_cnt_q != 4'd0) err_cnt_nxt = err_cnt_q - 4'd1;
               end else begin
                  good_cnt_nxt = good_inc;
               end
            end
         end
         default: begin
            state_nxt     = LOS;
            comma_cnt_nxt = 4'd0;
         end
      endcase
   end

   // Forwarding decision uses the pre-edge state, so the acquiring comma is
   // dropped and the symbol carrying the final error still goes out.
`ifdef RX_SYNC_COMMA_STRIP_EN
   assign fwd = bus.rx_valid & (state == SYNC) & ~comma_sym;
`else
   assign fwd = bus.rx_valid & (state == SYNC);
`endif

   // ev already folds in enb, so the FSM naturally holds when enb is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= LOS;
         comma_cnt   <= 4'd0;
         good_cnt    <= 4'd0;
         err_cnt_q   <= 4'd0;
         loss_q      <= 8'd0;
         comma_det_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         comma_cnt   <= comma_cnt_nxt;
         good_cnt    <= good_cnt_nxt;
         err_cnt_q   <= err_cnt_nxt;
         loss_q      <= loss_nxt;
         comma_det_q <= comma;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= 8'h00;
         ctrl_q  <= 1'b0;
         valid_q <= 1'b0;
      end else if (enb) begin
         data_q  <= bus.rx_data;
         ctrl_q  <= bus.rx_control;
         valid_q <= fwd;
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign bus.rx_dataS  = data_q;
   assign bus.rx_ctrlS  = ctrl_q;
   assign bus.rx_validS = valid_q;
   assign bus.sync_ok   = (state == SYNC);
   assign bus.comma_det = comma_det_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.loss_cnt  = loss_q;

endmodule
